// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Module : gcd_pkg
// Brief  : Shared types and default widths for the GCD dispatch slice.
// Rev    : 1.0  initial release
// ============================================================================
package gcd_pkg;

    localparam int c_GCD_WIDTH   = 32;
    localparam int c_GCD_DEPTH   = 4;
    localparam int c_GCD_TAG_W   = 8;
    localparam int c_GCD_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_ISSUE = 2'd1,
        D_WAIT  = 2'd2,
        D_HOLD  = 2'd3
    } dispatch_state_t;

    // Queue entry layout at the default widths; the dispatcher declares the
    // same layout locally when built with non-default parameters.
    typedef struct packed {
        logic [c_GCD_WIDTH-1:0] a;
        logic [c_GCD_WIDTH-1:0] b;
        logic [c_GCD_TAG_W-1:0] tag;
    } gcd_entry_t;

endpackage
`default_nettype wire

// File: rtl/gcd_op_fifo.sv
`default_nettype none
// ============================================================================
// Module : gcd_op_fifo
// Brief  : Synchronous circular FIFO with head-entry output for operand pairs.
// Rev    : 1.0  initial release
// ============================================================================
module gcd_op_fifo #(
    parameter int DW    = 72,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic          o_full,
    output logic          o_empty,
    output logic [DW-1:0] o_head
);

    localparam int c_AW = $clog2(DEPTH);

    // The extra MSB distinguishes full (wrapped) from empty (equal).
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic [DW-1:0]   r_mem [DEPTH];
    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/gcd_dispatch.sv
`default_nettype none
// ============================================================================
// Module : gcd_dispatch
// Brief  : Buffers operand pairs, issues them one at a time to the GCD core
//          and returns tagged results in order. Optional watchdog under
//          GCD_DISPATCH_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module gcd_dispatch
    import gcd_pkg::*;
#(
    parameter int WIDTH   = c_GCD_WIDTH,
    parameter int DEPTH   = c_GCD_DEPTH,
    parameter int TAG_W   = c_GCD_TAG_W,
    parameter int TIMEOUT = c_GCD_TIMEOUT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             core_ready,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result,
    output logic             core_ld,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } entry_t;

    dispatch_state_t r_state, w_state_nxt;

    logic [TAG_W-1:0] r_tag_cnt;
    logic [TAG_W-1:0] r_pend_tag,  w_pend_tag_nxt;
    logic             r_core_ld,   w_core_ld_nxt;
    logic [WIDTH-1:0] r_core_a,    w_core_a_nxt;
    logic [WIDTH-1:0] r_core_b,    w_core_b_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic [WIDTH-1:0] r_out_gcd,   w_out_gcd_nxt;
    logic [TAG_W-1:0] r_out_tag,   w_out_tag_nxt;
    logic             r_out_err,   w_out_err_nxt;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    entry_t           w_in_entry;
    entry_t           w_head;
    logic             w_wd_expired;

    assign in_ready   = !w_full;
    assign w_push     = in_valid && !w_full;
    assign w_in_entry = '{a: in_a, b: in_b, tag: r_tag_cnt};

    gcd_op_fifo #(
        .DW    ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_data  (w_in_entry),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk) begin
        if (!resetn) r_tag_cnt <= '0;
        else if (w_push) r_tag_cnt <= r_tag_cnt + 1'b1;
    end

`ifdef GCD_DISPATCH_TIMEOUT_EN
    localparam int                c_WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    // Held at zero outside D_WAIT, so it restarts on every entry.
    logic [c_WD_W-1:0] r_wdog;

    always_ff @(posedge clk) begin
        if (!resetn || r_state != D_WAIT) r_wdog <= '0;
        else                              r_wdog <= r_wdog + 1'b1;
    end

    assign w_wd_expired = (r_state == D_WAIT) && (r_wdog == c_WD_LAST);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_wd_expired     = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_pop           = 1'b0;
        w_pend_tag_nxt  = r_pend_tag;
        w_core_ld_nxt   = 1'b0;
        w_core_a_nxt    = r_core_a;
        w_core_b_nxt    = r_core_b;
        w_out_valid_nxt = r_out_valid;
        w_out_gcd_nxt   = r_out_gcd;
        w_out_tag_nxt   = r_out_tag;
        w_out_err_nxt   = r_out_err;
        case (r_state)
            D_IDLE: begin
                if (!w_empty) begin
                    // A zero operand makes the result the other operand.
                    if (w_head.a == '0 || w_head.b == '0) begin
                        w_pop           = 1'b1;
                        w_out_gcd_nxt   = w_head.a | w_head.b;
                        w_out_tag_nxt   = w_head.tag;
                        w_out_err_nxt   = 1'b0;
                        w_out_valid_nxt = 1'b1;
                        w_state_nxt     = D_HOLD;
                    end else if (core_ready) begin
                        w_pop          = 1'b1;
                        w_core_a_nxt   = w_head.a;
                        w_core_b_nxt   = w_head.b;
                        w_pend_tag_nxt = w_head.tag;
                        w_core_ld_nxt  = 1'b1;
                        w_state_nxt    = D_ISSUE;
                    end
                end
            end
            D_ISSUE: begin
                w_state_nxt = D_WAIT;
            end
            D_WAIT: begin
                if (core_done) begin
                    w_out_gcd_nxt   = core_result;
                    w_out_tag_nxt   = r_pend_tag;
                    w_out_err_nxt   = 1'b0;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = D_HOLD;
                end else if (w_wd_expired) begin
                    w_out_gcd_nxt   = '0;
                    w_out_tag_nxt   = r_pend_tag;
                    w_out_err_nxt   = 1'b1;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = D_HOLD;
                end
            end
            D_HOLD: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = D_IDLE;
                end
            end
            default: begin
                w_state_nxt = D_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= D_IDLE;
            r_pend_tag  <= '0;
            r_core_ld   <= 1'b0;
            r_core_a    <= '0;
            r_core_b    <= '0;
            r_out_valid <= 1'b0;
            r_out_gcd   <= '0;
            r_out_tag   <= '0;
            r_out_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend_tag  <= w_pend_tag_nxt;
            r_core_ld   <= w_core_ld_nxt;
            r_core_a    <= w_core_a_nxt;
            r_core_b    <= w_core_b_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_gcd   <= w_out_gcd_nxt;
            r_out_tag   <= w_out_tag_nxt;
            r_out_err   <= w_out_err_nxt;
        end
    end

    assign core_ld   = r_core_ld;
    assign core_a    = r_core_a;
    assign core_b    = r_core_b;
    assign out_valid = r_out_valid;
    assign out_gcd   = r_out_gcd;
    assign out_tag   = r_out_tag;
    assign out_err   = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_gcd_dispatch.sv
`default_nettype none
// ============================================================================
// Module : tb_gcd_dispatch
// Brief  : Self-checking bench for gcd_dispatch with a behavioural GCD core.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gcd_dispatch;

    localparam int W  = 32;
    localparam int TW = 8;
`ifdef GCD_DISPATCH_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 1023;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          core_ready = 1'b0;
    logic          core_done = 1'b0;
    logic [W-1:0]  core_result = '0;
    logic          core_ld;
    logic [W-1:0]  core_a;
    logic [W-1:0]  core_b;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_gcd;
    logic [TW-1:0] out_tag;
    logic          out_err;

    gcd_dispatch #(
        .WIDTH   (W),
        .DEPTH   (4),
        .TAG_W   (TW),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .core_ready  (core_ready),
        .core_done   (core_done),
        .core_result (core_result),
        .core_ld     (core_ld),
        .core_a      (core_a),
        .core_b      (core_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_gcd     (out_gcd),
        .out_tag     (out_tag),
        .out_err     (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  g;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          sb_e;
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            acc_cyc = 0;
    logic [TW-1:0] tb_tag = '0;

    bit            core_en = 1'b1;
    bit            hang = 1'b0;
    bit            busy = 1'b0;
    int            busy_cnt = 0;
    int            lat = 3;
    logic [W-1:0]  res = '0;
    int            done_cyc = 0;
    int            ld_cnt = 0;
    int            ld_cyc = 0;
    logic [W-1:0]  ld_a = '0;
    logic [W-1:0]  ld_b = '0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", name, obs, expv, cyc);
        end
    endtask

    // Reference: Euclid by remainder; the core model uses repeated subtraction.
    function automatic logic [W-1:0] gcd_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [W-1:0] gcd_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 0 || b == 0) return a | b;
        while (a != b) begin
            if (a > b) a = a - b;
            else       b = b - a;
        end
        return a;
    endfunction

    always @(posedge clk) cyc++;

    // Behavioural core, driven away from the active edge.
    always @(negedge clk) begin
        core_done = 1'b0;
        if (!resetn) begin
            busy = 1'b0;
        end else if (busy) begin
            if (busy_cnt > 0) busy_cnt--;
            else if (!hang) begin
                core_done   = 1'b1;
                core_result = res;
                busy        = 1'b0;
                done_cyc    = cyc;
            end
        end else if (core_ld) begin
            busy     = 1'b1;
            res      = gcd_sub(core_a, core_b);
            busy_cnt = lat;
        end
        core_ready = !busy && core_en;
    end

    always @(negedge clk) begin
        if (resetn) begin
            if (core_ld) begin
                ld_cnt++;
                ld_cyc = cyc;
                ld_a   = core_a;
                ld_b   = core_b;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_valid, 1'b0);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_gcd", out_gcd, sb_e.g);
                    check("sb_tag", out_tag, sb_e.tag);
                    check("sb_err", out_err, sb_e.err);
                end
            end
        end
    end

    task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic accept_wait();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("accept_timeout", in_ready, 1'b1);
        if (in_ready) begin
            exp_q.push_back('{g: gcd_mod(in_a, in_b), tag: tb_tag, err: 1'b0});
            acc_cyc = cyc;
            tb_tag++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        offer(a, b);
        accept_wait();
    endtask

    task automatic wait_valid(output int vc);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("valid_timeout", out_valid, 1'b1);
        vc = cyc;
    endtask

    task automatic wait_ld(input int prev);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (ld_cnt != prev) break;
        end
        check("ld_timeout", (ld_cnt != prev), 1'b1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int            vc;
        int            l0;
        int            t_acc;
        logic [W-1:0]  sg;
        logic [TW-1:0] st;
        bit            stable;

        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_core_ld",   core_ld,   1'b0);
        check("rst_out_err",   out_err,   1'b0);
        check("rst_out_gcd",   out_gcd,   0);
        check("rst_out_tag",   out_tag,   0);
        check("rst_core_a",    core_a,    0);
        check("rst_core_b",    core_b,    0);
        check("rst_in_ready",  in_ready,  1'b1);

        // Basic issue and result hold
        out_ready = 1'b0;
        l0 = ld_cnt;
        push(48, 18);
        t_acc = acc_cyc;
        wait_ld(l0);
        check("ld_latency", ld_cyc - t_acc, 2);
        check("ld_core_a", ld_a, 48);
        check("ld_core_b", ld_b, 18);
        @(negedge clk);
        check("ld_single_pulse", core_ld, 1'b0);
        check("core_a_stable", core_a, 48);
        wait_valid(vc);
        check("done_to_valid", vc - done_cyc, 1);
        check("basic_gcd", out_gcd, 6);
        check("basic_tag", out_tag, 0);
        repeat (3) @(negedge clk);
        check("valid_held", out_valid, 1'b1);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        check("valid_dropped", out_valid, 1'b0);
        check("basic_ld_count", ld_cnt - l0, 1);

        // Zero bypass
        @(posedge clk); #1 out_ready = 1'b0;
        l0 = ld_cnt;
        push(0, 35);
        t_acc = acc_cyc;
        wait_valid(vc);
        check("bypass_latency", vc - t_acc, 2);
        @(posedge clk); #1 out_ready = 1'b1;
        push(0, 0);
        wait_drain();
        check("bypass_no_ld", ld_cnt - l0, 0);

        // Full FIFO with the core held busy
        core_en = 1'b0;
        l0 = ld_cnt;
        push(12, 8);
        push(21, 14);
        push(100, 75);
        push(17, 5);
        check("full_in_ready_after4", in_ready, 1'b0);
        offer(9, 6);
        repeat (3) @(negedge clk);
        check("full_in_ready", in_ready, 1'b0);
        check("full_no_ld", ld_cnt - l0, 0);
        core_en = 1'b1;
        accept_wait();
        push(81, 27);
        wait_drain();
        check("full_ld_count", ld_cnt - l0, 6);

        // Output backpressure
        @(posedge clk); #1 out_ready = 1'b0;
        push(54, 24);
        wait_valid(vc);
        sg = out_gcd;
        st = out_tag;
        l0 = ld_cnt;
        push(30, 12);
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || out_gcd !== sg || out_tag !== st) stable = 1'b0;
        end
        check("hold_stable", stable, 1'b1);
        check("hold_gcd", sg, 6);
        check("hold_no_ld", ld_cnt - l0, 0);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain();

        // Reset while waiting on the core with work queued
        hang = 1'b1;
        l0 = ld_cnt;
        push(10, 4);
        wait_ld(l0);
        push(3, 6);
        push(8, 4);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 resetn = 1'b0;
        exp_q.delete();
        tb_tag = '0;
        hang   = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_in_ready",  in_ready,  1'b1);
        check("mid_rst_core_ld",   core_ld,   1'b0);
        push(15, 10);
        wait_valid(vc);
        check("post_reset_tag", out_tag, 0);
        check("post_reset_gcd", out_gcd, 5);
        wait_drain();

`ifdef GCD_DISPATCH_TIMEOUT_EN
        // Watchdog expiry, then the late core result must be ignored
        hang = 1'b1;
        l0 = ld_cnt;
        push(9, 3);
        sb_e = exp_q.pop_back();
        sb_e.g   = '0;
        sb_e.err = 1'b1;
        exp_q.push_back(sb_e);
        wait_ld(l0);
        wait_valid(vc);
        check("timeout_latency", vc - ld_cyc, TB_TIMEOUT + 1);
        check("timeout_err", out_err, 1'b1);
        check("timeout_gcd", out_gcd, 0);
        wait_drain();
        hang = 1'b0;
        stable = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stable = 1'b0;
        end
        check("late_done_ignored", stable, 1'b1);
        push(27, 18);
        wait_drain();
`endif

        // Tag wrap through the zero-bypass path
        for (int i = 0; i < 260; i++) begin
            push(0, W'(i + 1));
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
